// File: rtl/playfield_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : playfield_controller_pkg
// Purpose : Shared display types for the playfield controller and the pixel
//           driver: tile encoding, garbage colour, playfield geometry and
//           the controller state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package playfield_controller_pkg;

  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;

  // BLANK must stay at zero: the pixel driver treats 0 as "draw nothing".
  typedef enum logic [3:0] {
    BLANK  = 4'd0,
    TILE_I = 4'd1,
    TILE_O = 4'd2,
    TILE_T = 4'd3,
    TILE_S = 4'd4,
    TILE_Z = 4'd5,
    TILE_J = 4'd6,
    TILE_L = 4'd7,
    GARB   = 4'd8
  } tile_type_t;

  // RGB888 colour the pixel driver uses for GARB tiles.
  localparam logic [23:0] GARBAGE_COLOR = 24'h7F7F7F;

  typedef enum logic [2:0] {
    PFC_IDLE    = 3'd0,
    PFC_WRITE   = 3'd1,
    PFC_SCAN    = 3'd2,
    PFC_CLEAR   = 3'd3,
    PFC_GARBAGE = 3'd4,
    PFC_DONE    = 3'd5
  } pfc_state_t;

  function automatic logic tile_occupied(input tile_type_t t);
    return (t != BLANK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/playfield_controller_row_full.sv
`default_nettype none
// ============================================================================
// Module  : playfield_row_full
// Purpose : Combinational full-row detector. A row is full when none of its
//           cells is BLANK.
// Ports   : row_i  - one playfield row (COLS tiles)
//           full_o - high when every cell of row_i is occupied
// Revision: 1.0 - initial release
// ============================================================================
module playfield_row_full
  import playfield_controller_pkg::*;
#(
  parameter int COLS = PLAYFIELD_COLS
) (
  input  tile_type_t row_i [COLS],
  output logic       full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (!tile_occupied(row_i[c])) begin
        full_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/playfield_controller.sv
`default_nettype none
// ============================================================================
// Module  : playfield_controller
// Purpose : Sole writer of the playfield tile array. Serialises piece-lock
//           and garbage-insertion requests, clears full rows after each lock
//           and drives the registered tile array to the pixel driver.
// Config  : PLAYFIELD_GARBAGE_EN - when defined, the garbage request port and
//           GARBAGE state are active; otherwise garbage_ready_o and top_out_o
//           are tied low and the garbage inputs are ignored.
// Ports   : clk_i, reset_n_i            - clock, async active-low reset
//           lock_valid_i/lock_ready_o   - piece-lock handshake
//           lock_row_i/lock_col_i       - 4 cell coordinates of the piece
//           lock_type_i                 - tile type written to the 4 cells
//           garbage_valid_i/ready_o     - garbage handshake
//           garbage_count_i             - garbage rows to insert (0..4)
//           garbage_hole_i              - empty column of each garbage row
//           tile_type_o                 - registered playfield contents
//           busy_o                      - controller not idle
//           done_o                      - one-cycle completion pulse
//           lines_cleared_o             - rows cleared by last operation
//           top_out_o                   - sticky: tile pushed off row 0
// Revision: 1.0 - initial release
// ============================================================================
module playfield_controller
  import playfield_controller_pkg::*;
#(
  parameter int ROWS = PLAYFIELD_ROWS,
  parameter int COLS = PLAYFIELD_COLS
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       lock_valid_i,
  output logic       lock_ready_o,
  input  logic [4:0] lock_row_i [4],
  input  logic [3:0] lock_col_i [4],
  input  tile_type_t lock_type_i,
  input  logic       garbage_valid_i,
  output logic       garbage_ready_o,
  input  logic [2:0] garbage_count_i,
  input  logic [3:0] garbage_hole_i,
  output tile_type_t tile_type_o [ROWS][COLS],
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] lines_cleared_o,
  output logic       top_out_o
);

  localparam int RW = $clog2(ROWS);

  pfc_state_t    state_q;
  tile_type_t    tiles_q [ROWS][COLS];
  logic [RW-1:0] row_q;
  logic [4:0]    lrow_q [4];
  logic [3:0]    lcol_q [4];
  tile_type_t    ltype_q;
  logic [2:0]    clr_cnt_q;
  logic          done_q;

  tile_type_t    scan_row [COLS];
  logic          scan_full;
  logic          accept_state;
  logic          lock_acc;
  logic          garb_acc;

  // DONE accepts like IDLE so back-to-back requests lose no cycle; the
  // request taken on the edge that ends DONE starts the next operation.
  assign accept_state    = (state_q == PFC_IDLE) || (state_q == PFC_DONE);
  assign lock_ready_o    = accept_state;
  assign lock_acc        = lock_valid_i && accept_state;
  assign busy_o          = (state_q != PFC_IDLE);
  assign done_o          = done_q;
  assign lines_cleared_o = clr_cnt_q;
  assign tile_type_o     = tiles_q;

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      scan_row[c] = tiles_q[row_q][c];
    end
  end

  playfield_row_full #(
    .COLS (COLS)
  ) u_row_full (
    .row_i  (scan_row),
    .full_o (scan_full)
  );

`ifdef PLAYFIELD_GARBAGE_EN
  logic [2:0] gcnt_q;
  logic [3:0] ghole_q;
  logic       top_out_q;
  logic       row0_occupied;

  assign garbage_ready_o = accept_state && !lock_valid_i;
  assign garb_acc        = garbage_valid_i && garbage_ready_o;
  assign top_out_o       = top_out_q;

  always_comb begin
    row0_occupied = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (tile_occupied(tiles_q[0][c])) begin
        row0_occupied = 1'b1;
      end
    end
  end
`else
  logic garbage_unused;
  assign garbage_unused  = ^{garbage_valid_i, garbage_count_i, garbage_hole_i};
  assign garbage_ready_o = 1'b0;
  assign garb_acc        = 1'b0;
  assign top_out_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= PFC_IDLE;
      row_q     <= '0;
      ltype_q   <= BLANK;
      clr_cnt_q <= '0;
      done_q    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        lrow_q[k] <= '0;
        lcol_q[k] <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          tiles_q[r][c] <= BLANK;
        end
      end
`ifdef PLAYFIELD_GARBAGE_EN
      gcnt_q    <= '0;
      ghole_q   <= '0;
      top_out_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PFC_IDLE, PFC_DONE: begin
          state_q <= PFC_IDLE;
          if (lock_acc) begin
            for (int k = 0; k < 4; k++) begin
              lrow_q[k] <= lock_row_i[k];
              lcol_q[k] <= lock_col_i[k];
            end
            ltype_q   <= lock_type_i;
            clr_cnt_q <= '0;
`ifdef PLAYFIELD_GARBAGE_EN
            top_out_q <= 1'b0;
`endif
            state_q   <= PFC_WRITE;
          end
`ifdef PLAYFIELD_GARBAGE_EN
          else if (garb_acc) begin
            clr_cnt_q <= '0;
            top_out_q <= 1'b0;
            gcnt_q    <= garbage_count_i;
            // Out-of-range hole positions fall back to column 0.
            ghole_q   <= (int'(garbage_hole_i) >= COLS) ? 4'd0 : garbage_hole_i;
            if (garbage_count_i == 3'd0) begin
              state_q <= PFC_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= PFC_GARBAGE;
            end
          end
`endif
        end

        PFC_WRITE: begin
          // Off-board cells are silently dropped; occupied cells overwritten.
          for (int k = 0; k < 4; k++) begin
            if (int'(lrow_q[k]) < ROWS && int'(lcol_q[k]) < COLS) begin
              tiles_q[lrow_q[k]][lcol_q[k]] <= ltype_q;
            end
          end
          row_q   <= RW'(ROWS - 1);
          state_q <= PFC_SCAN;
        end

        PFC_SCAN: begin
          if (scan_full) begin
            state_q <= PFC_CLEAR;
          end else if (row_q == '0) begin
            state_q <= PFC_DONE;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_q - RW'(1);
          end
        end

        PFC_CLEAR: begin
          // Everything above the full row drops one row; the pointer stays
          // put so the row that fell into place is re-tested.
          for (int r = ROWS - 1; r >= 1; r--) begin
            if (r <= int'(row_q)) begin
              for (int c = 0; c < COLS; c++) begin
                tiles_q[r][c] <= tiles_q[r-1][c];
              end
            end
          end
          for (int c = 0; c < COLS; c++) begin
            tiles_q[0][c] <= BLANK;
          end
          if (clr_cnt_q != 3'd7) begin
            clr_cnt_q <= clr_cnt_q + 3'd1;
          end
          state_q <= PFC_SCAN;
        end

`ifdef PLAYFIELD_GARBAGE_EN
        PFC_GARBAGE: begin
          for (int r = 0; r < ROWS - 1; r++) begin
            for (int c = 0; c < COLS; c++) begin
              tiles_q[r][c] <= tiles_q[r+1][c];
            end
          end
          for (int c = 0; c < COLS; c++) begin
            tiles_q[ROWS-1][c] <= (c == int'(ghole_q)) ? BLANK : GARB;
          end
          if (row0_occupied) begin
            top_out_q <= 1'b1;
          end
          gcnt_q <= gcnt_q - 3'd1;
          if (gcnt_q == 3'd1) begin
            state_q <= PFC_DONE;
            done_q  <= 1'b1;
          end
        end
`endif

        default: begin
          state_q <= PFC_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_playfield_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_playfield_controller
// Purpose : Self-checking bench for playfield_controller. A reference board
//           model predicts contents, clear count and completion latency of
//           each request; expectations are queued on issue and retired when
//           done pulses.
// Revision: 1.0 - initial release
// ============================================================================
module tb_playfield_controller;
  import playfield_controller_pkg::*;

  localparam int ROWS = PLAYFIELD_ROWS;
  localparam int COLS = PLAYFIELD_COLS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lock_valid = 1'b0;
  logic       lock_ready;
  logic [4:0] lock_row [4];
  logic [3:0] lock_col [4];
  tile_type_t lock_type = BLANK;
  logic       garbage_valid = 1'b0;
  logic       garbage_ready;
  logic [2:0] garbage_count = '0;
  logic [3:0] garbage_hole = '0;
  tile_type_t tile_type [ROWS][COLS];
  logic       busy;
  logic       done;
  logic [2:0] lines_cleared;
  logic       top_out;

  always #5 clk = ~clk;

  playfield_controller dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .lock_valid_i    (lock_valid),
    .lock_ready_o    (lock_ready),
    .lock_row_i      (lock_row),
    .lock_col_i      (lock_col),
    .lock_type_i     (lock_type),
    .garbage_valid_i (garbage_valid),
    .garbage_ready_o (garbage_ready),
    .garbage_count_i (garbage_count),
    .garbage_hole_i  (garbage_hole),
    .tile_type_o     (tile_type),
    .busy_o          (busy),
    .done_o          (done),
    .lines_cleared_o (lines_cleared),
    .top_out_o       (top_out)
  );

  typedef struct {
    int lat;
    int lines;
    int top;
  } exp_t;

  exp_t       sb [$];
  tile_type_t mdl [ROWS][COLS];
  int         mdl_top;
  int         n_checks = 0;
  int         n_errors = 0;

`ifdef PLAYFIELD_GARBAGE_EN
  localparam int GARB_EN = 1;
`else
  localparam int GARB_EN = 0;
`endif

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int board_mism();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (tile_type[r][c] !== mdl[r][c]) n++;
    return n;
  endfunction

  function automatic int occupied_count();
    int n = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (tile_type[r][c] !== BLANK) n++;
    return n;
  endfunction

  task automatic mdl_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mdl[r][c] = BLANK;
    mdl_top = 0;
  endtask

  // Reference: place cells, then drop every full row and compact the rest.
  task automatic mdl_lock(input tile_type_t t, output int k);
    tile_type_t nb [ROWS][COLS];
    int dst;
    logic full;
    for (int i = 0; i < 4; i++)
      if (int'(lock_row[i]) < ROWS && int'(lock_col[i]) < COLS)
        mdl[lock_row[i]][lock_col[i]] = t;
    k = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (mdl[r][c] == BLANK) full = 1'b0;
      if (full) k++;
      else begin
        for (int c = 0; c < COLS; c++) nb[dst][c] = mdl[r][c];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--)
      for (int c = 0; c < COLS; c++) nb[r][c] = BLANK;
    mdl = nb;
    mdl_top = 0;
  endtask

  task automatic mdl_garb(input int n, input int hole);
    int h;
    h = (hole >= COLS) ? 0 : hole;
    mdl_top = 0;
    repeat (n) begin
      for (int c = 0; c < COLS; c++)
        if (mdl[0][c] != BLANK) mdl_top = 1;
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r+1][c];
      for (int c = 0; c < COLS; c++) mdl[ROWS-1][c] = (c == h) ? BLANK : GARB;
    end
  endtask

  task automatic set_cells(input int r0, input int c0, input int r1, input int c1,
                           input int r2, input int c2, input int r3, input int c3);
    lock_row[0] = 5'(r0); lock_col[0] = 4'(c0);
    lock_row[1] = 5'(r1); lock_col[1] = 4'(c1);
    lock_row[2] = 5'(r2); lock_col[2] = 4'(c2);
    lock_row[3] = 5'(r3); lock_col[3] = 4'(c3);
  endtask

  task automatic push_lock(input tile_type_t t);
    int k;
    exp_t e;
    mdl_lock(t, k);
    e.lat = ROWS + 2 + 2 * k;
    e.lines = (k > 7) ? 7 : k;
    e.top = 0;
    sb.push_back(e);
  endtask

  // Called #1 after an edge with the DUT able to accept; returns in cycle 1.
  task automatic issue_lock(input tile_type_t t);
    check("lock_ready_before_issue", lock_ready, 1);
    lock_type = t;
    lock_valid = 1'b1;
    @(posedge clk); #1;
    lock_valid = 1'b0;
    push_lock(t);
  endtask

  task automatic push_garb(input int n, input int h);
    exp_t e;
    mdl_garb(n, h);
    e.lat = n + 1;
    e.lines = 0;
    e.top = mdl_top;
    sb.push_back(e);
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(input string tag);
    int cyc;
    exp_t e;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, " done_cycle"}, cyc, e.lat);
    check({tag, " lines_cleared"}, int'(lines_cleared), e.lines);
    check({tag, " top_out"}, int'(top_out), (GARB_EN != 0) ? e.top : 0);
    check({tag, " board_mismatches"}, board_mism(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    mdl_clear();
    sb.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      lock_row[i] = '0;
      lock_col[i] = '0;
    end
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst lines_cleared", int'(lines_cleared), 0);
    check("rst top_out", int'(top_out), 0);
    check("rst lock_ready", int'(lock_ready), 1);
    check("rst garbage_ready", int'(garbage_ready), GARB_EN);
    check("rst occupied", occupied_count(), 0);

    // T piece, no clear
    set_cells(19, 0, 19, 1, 19, 2, 18, 1);
    issue_lock(TILE_T);
    check("t_lock busy", int'(busy), 1);
    check("t_lock ready_while_busy", int'(lock_ready), 0);
    wait_done("t_lock");
    check("t_lock cell_19_0", int'(tile_type[19][0]), int'(TILE_T));
    check("t_lock cell_19_2", int'(tile_type[19][2]), int'(TILE_T));
    check("t_lock cell_18_1", int'(tile_type[18][1]), int'(TILE_T));
    check("t_lock occupied", occupied_count(), 4);
    @(posedge clk); #1;
    check("t_lock done_width", int'(done), 0);
    check("t_lock idle", int'(busy), 0);

    // Fill row 19 up to col 5, including off-board cells that must be dropped
    set_cells(19, 3, 19, 4, 25, 0, 3, 11);
    issue_lock(TILE_O);
    wait_done("prefill_a");
    set_cells(19, 5, 31, 15, 20, 0, 0, 10);
    issue_lock(TILE_O);
    wait_done("prefill_b");
    check("prefill occupied", occupied_count(), 7);

    // Horizontal I completes row 19: one clear
    set_cells(19, 6, 19, 7, 19, 8, 19, 9);
    issue_lock(TILE_I);
    wait_done("single_clear");
    check("single_clear row19_from_row18", int'(tile_type[19][1]), int'(TILE_T));
    check("single_clear row19_col0", int'(tile_type[19][0]), int'(BLANK));
    check("single_clear occupied", occupied_count(), 1);

    // Four rows missing col 9, then a vertical I: tetris
    do_reset();
    for (int g = 0; g < 9; g++) begin
      set_cells(16 + (4*g) / 9, (4*g) % 9, 16 + (4*g+1) / 9, (4*g+1) % 9,
                16 + (4*g+2) / 9, (4*g+2) % 9, 16 + (4*g+3) / 9, (4*g+3) % 9);
      issue_lock(TILE_J);
      wait_done("stack");
    end
    check("stack occupied", occupied_count(), 36);
    set_cells(16, 9, 17, 9, 18, 9, 19, 9);
    issue_lock(TILE_I);
    wait_done("tetris");
    check("tetris occupied", occupied_count(), 0);

    // Simultaneous requests: lock wins
    set_cells(19, 0, 19, 1, 19, 2, 19, 3);
    lock_type = TILE_S;
    garbage_count = 3'd1;
    garbage_hole = 4'd3;
    lock_valid = 1'b1;
    garbage_valid = 1'b1;
    #1;
    check("prio garbage_ready", int'(garbage_ready), 0);
    check("prio lock_ready", int'(lock_ready), 1);
    @(posedge clk); #1;
    lock_valid = 1'b0;
    push_lock(TILE_S);
    wait_done("prio_lock");
`ifdef PLAYFIELD_GARBAGE_EN
    check("prio garbage_ready_in_done", int'(garbage_ready), 1);
    @(posedge clk); #1;
    garbage_valid = 1'b0;
    push_garb(1, 3);
    wait_done("prio_garb");
`else
    check("prio garbage_ready_in_done", int'(garbage_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    garbage_valid = 1'b0;
    check("prio garbage_ignored busy", int'(busy), 0);
    check("prio garbage_ignored board", board_mism(), 0);
`endif

`ifdef PLAYFIELD_GARBAGE_EN
    // Garbage pushes a row-0 tile off the top
    do_reset();
    set_cells(0, 5, 1, 5, 2, 5, 3, 5);
    issue_lock(TILE_Z);
    wait_done("tower");
    check("garb ready", int'(garbage_ready), 1);
    garbage_count = 3'd2; garbage_hole = 4'd3; garbage_valid = 1'b1;
    @(posedge clk); #1;
    garbage_valid = 1'b0;
    push_garb(2, 3);
    wait_done("garb2");
    check("garb2 row19_hole", int'(tile_type[19][3]), int'(BLANK));
    check("garb2 row18_col0", int'(tile_type[18][0]), int'(GARB));
    check("garb2 top_out_sticky", int'(top_out), 1);
    // Out-of-range hole falls back to col 0
    garbage_count = 3'd1; garbage_hole = 4'd12; garbage_valid = 1'b1;
    @(posedge clk); #1;
    garbage_valid = 1'b0;
    push_garb(1, 12);
    wait_done("garb_hole_oor");
    check("garb_hole_oor col0", int'(tile_type[19][0]), int'(BLANK));
    // Zero-count garbage completes immediately and clears top_out
    garbage_count = 3'd0; garbage_hole = 4'd0; garbage_valid = 1'b1;
    @(posedge clk); #1;
    garbage_valid = 1'b0;
    push_garb(0, 0);
    wait_done("garb_zero");
`endif

    // Reset in the middle of CLEAR
    do_reset();
    set_cells(19, 0, 19, 1, 19, 2, 19, 3);
    issue_lock(TILE_L);
    wait_done("pre_abort_a");
    set_cells(19, 4, 19, 5, 25, 0, 25, 1);
    issue_lock(TILE_L);
    wait_done("pre_abort_b");
    set_cells(19, 6, 19, 7, 19, 8, 19, 9);
    issue_lock(TILE_I);
    @(posedge clk);
    @(posedge clk); #1;
    check("abort busy_in_clear", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("abort occupied", occupied_count(), 0);
    check("abort busy", int'(busy), 0);
    check("abort lock_ready", int'(lock_ready), 1);
    check("abort done", int'(done), 0);
    mdl_clear();
    sb.delete();
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_cells(19, 0, 18, 0, 17, 0, 16, 0);
    issue_lock(TILE_I);
    wait_done("post_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
